// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer definitions for the 3D renderer's write side and the VGA
// read side: the on-screen 3D window, the cylinder-pipeline column shift,
// the per-bank depth, the writer state type and the RGB444 packer.
// -----------------------------------------------------------------------------
package fb_pkg;

  // 3D window on the VGA raster; X/Y ends are exclusive.
  localparam int unsigned START_X       = 390;
  localparam int unsigned START_Y       = 390;
  localparam int unsigned END_X         = 634;
  localparam int unsigned END_Y         = 765;

  // Above this vcount the cylinder pipeline delivers pixels CYL_SHIFT columns late.
  localparam int unsigned REGION_DIVIDE = 530;
  localparam int unsigned CYL_SHIFT     = 2;

  // Pixels per bank: 244 x 375 = 91500.
  localparam int unsigned FB_DEPTH      = (END_X - START_X) * (END_Y - START_Y);

  typedef enum logic [0:0] {
    WRITING   = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_t;

  // Keeps the top nibble of each 8-bit channel.
  function automatic logic [11:0] pack_rgb444(input logic [3:0] r_hi,
                                              input logic [3:0] g_hi,
                                              input logic [3:0] b_hi);
    return {r_hi, g_hi, b_hi};
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// -----------------------------------------------------------------------------
// fb_addr_calc
// Combinational coordinate-to-address mapping for one frame-buffer bank.
// Subtracts the column shift, checks the coordinate against the 3D window and
// forms the linear pixel address. The read side instantiates it with shift_i=0.
//
// Ports:
//   hcount_i    - raster column tag
//   vcount_i    - raster row tag
//   shift_i     - column offset subtracted from hcount_i
//   h_eff_o     - hcount_i - shift_i (meaningful only when in_window_o)
//   in_window_o - coordinate lies inside the window, with no wrap below zero
//   addr_o      - pixel address inside the bank (meaningful only when in_window_o)
// -----------------------------------------------------------------------------
module fb_addr_calc #(
  parameter int unsigned START_X = fb_pkg::START_X,
  parameter int unsigned START_Y = fb_pkg::START_Y,
  parameter int unsigned END_X   = fb_pkg::END_X,
  parameter int unsigned END_Y   = fb_pkg::END_Y,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic [10:0]       hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic [10:0]       shift_i,
  output logic [10:0]       h_eff_o,
  output logic              in_window_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              h_under;
  logic [ADDR_W-1:0] h_off;
  logic [ADDR_W-1:0] v_off;

  // A column left of the shift would wrap to a huge h_eff; treat it as outside.
  assign h_under = hcount_i < shift_i;
  assign h_eff_o = hcount_i - shift_i;

  assign in_window_o = !h_under
                    && (h_eff_o  >= 11'(START_X)) && (h_eff_o  < 11'(END_X))
                    && (vcount_i >= 10'(START_Y)) && (vcount_i < 10'(END_Y));

  // Arithmetic modulo 2^ADDR_W yields the same low bits as the wider
  // unsigned form, and every in-window address fits in ADDR_W bits.
  assign h_off  = ADDR_W'(h_eff_o)  - ADDR_W'(START_X);
  assign v_off  = ADDR_W'(vcount_i) - ADDR_W'(START_Y);
  assign addr_o = h_off + v_off * ADDR_W'(END_X - START_X);

endmodule

// File: rtl/fb_stream_writer.sv
// -----------------------------------------------------------------------------
// fb_stream_writer
// AXI-stream sink for the renderer's pixel output. Packs each pixel to RGB444,
// maps its hcount/vcount tag to a frame-buffer address and drives port A of a
// double-banked BRAM. After the last window pixel it stops accepting beats
// until the display side requests a bank swap at vsync.
//
// Ports:
//   aclk, aresetn          - clock, synchronous active-low reset
//   pixel_axis_tdata/valid - pixel beat {R,G,B}; pixel_axis_tready back-pressure
//   hcount_in, vcount_in   - raster tag of the current beat
//   swap_req               - single-cycle swap request from the display side
//   ram_we/addr/din        - RAM port A, one cycle after the accepted beat
//   rd_bank                - bank the VGA reader must display
//   frame_done             - pulse when the last window pixel is written
//   oob_err                - sticky: an accepted beat fell outside the window
//   frame_count            - completed-and-swapped frames, wraps at 255
// -----------------------------------------------------------------------------
module fb_stream_writer #(
  parameter int unsigned START_X       = fb_pkg::START_X,
  parameter int unsigned START_Y       = fb_pkg::START_Y,
  parameter int unsigned END_X         = fb_pkg::END_X,
  parameter int unsigned END_Y         = fb_pkg::END_Y,
  parameter int unsigned REGION_DIVIDE = fb_pkg::REGION_DIVIDE,
  parameter int unsigned CYL_SHIFT     = fb_pkg::CYL_SHIFT,
  parameter int unsigned ADDR_W        = 17
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              swap_req,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [11:0]       ram_din,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              oob_err,
  output logic [7:0]        frame_count
);

  fb_pkg::fb_state_t state_q, state_d;

  logic              tready_q;
  logic              we_q;
  logic [ADDR_W:0]   addr_q;
  logic [11:0]       din_q;
  logic              wr_bank_q;
  logic              frame_done_q;
  logic              oob_q;
  logic [7:0]        frame_count_q;

  logic [10:0]       shift;
  logic [10:0]       h_eff;
  logic              in_window;
  logic [ADDR_W-1:0] pix_addr;
  logic              accept;
  logic              wr_fire;
  logic              oob_fire;
  logic              at_last;
  logic              last_fire;
  logic              swap_fire;
  logic [11:0]       unused_low_nibbles;

  assign shift = (vcount_in < 10'(REGION_DIVIDE)) ? 11'(CYL_SHIFT) : 11'd0;

  fb_addr_calc #(
    .START_X (START_X),
    .START_Y (START_Y),
    .END_X   (END_X),
    .END_Y   (END_Y),
    .ADDR_W  (ADDR_W)
  ) u_addr_calc (
    .hcount_i    (hcount_in),
    .vcount_i    (vcount_in),
    .shift_i     (shift),
    .h_eff_o     (h_eff),
    .in_window_o (in_window),
    .addr_o      (pix_addr)
  );

  // RGB444 drops the low nibble of every channel.
  assign unused_low_nibbles = {pixel_axis_tdata[19:16], pixel_axis_tdata[11:8],
                               pixel_axis_tdata[3:0]};

  // tready is low outside WRITING, so no beat is ever accepted in WAIT_SWAP.
  assign accept   = pixel_axis_tvalid && tready_q;
  assign wr_fire  = accept && in_window;
  assign oob_fire = accept && !in_window;
  assign at_last  = (h_eff == 11'(END_X - 1)) && (vcount_in == 10'(END_Y - 1));

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    last_fire = 1'b0;
    swap_fire = 1'b0;
    case (state_q)
      fb_pkg::WRITING: begin
        // swap_req is deliberately ignored here, including on the last-pixel cycle.
        if (wr_fire && at_last) begin
          last_fire = 1'b1;
          state_d   = fb_pkg::WAIT_SWAP;
        end
      end
      fb_pkg::WAIT_SWAP: begin
        if (swap_req) begin
          swap_fire = 1'b1;
          state_d   = fb_pkg::WRITING;
        end
      end
      default: state_d = fb_pkg::WRITING;
    endcase
  end

  // NOTE: registers are assigned with <= so every flop samples the values from
  // before the edge; blocking = here would let later lines see updated state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= fb_pkg::WRITING;
      tready_q      <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      wr_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      oob_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      // Registered from the next state so tready drops on the same cycle the
      // FSM enters WAIT_SWAP and rises on the cycle it returns to WRITING.
      tready_q     <= (state_d == fb_pkg::WRITING);
      we_q         <= wr_fire;
      frame_done_q <= last_fire;
      oob_q        <= oob_q | oob_fire;
      if (wr_fire) begin
        addr_q <= {wr_bank_q, pix_addr};
        din_q  <= fb_pkg::pack_rgb444(pixel_axis_tdata[23:20],
                                      pixel_axis_tdata[15:12],
                                      pixel_axis_tdata[7:4]);
      end
      if (swap_fire) begin
        wr_bank_q     <= ~wr_bank_q;
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign pixel_axis_tready = tready_q;
  assign ram_we            = we_q;
  assign ram_addr          = addr_q;
  assign ram_din           = din_q;
  // The reader always shows the bank the writer is not filling.
  assign rd_bank           = ~wr_bank_q;
  assign frame_done        = frame_done_q;
  assign oob_err           = oob_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_stream_writer
// Directed bench for fb_stream_writer with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge, so a beat accepted on edge N is observed right after edge N.
// -----------------------------------------------------------------------------
module tb_fb_stream_writer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [23:0] pixel_axis_tdata;
  logic        pixel_axis_tvalid;
  logic        pixel_axis_tready;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        swap_req;
  logic        ram_we;
  logic [17:0] ram_addr;
  logic [11:0] ram_din;
  logic        rd_bank;
  logic        frame_done;
  logic        oob_err;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  localparam int BANK1 = 131072;  // ram_addr bit 17
  localparam int LAST_ADDR = 91499;

  always #5 aclk = ~aclk;

  fb_stream_writer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .pixel_axis_tdata  (pixel_axis_tdata),
    .pixel_axis_tvalid (pixel_axis_tvalid),
    .pixel_axis_tready (pixel_axis_tready),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .swap_req          (swap_req),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_din           (ram_din),
    .rd_bank           (rd_bank),
    .frame_done        (frame_done),
    .oob_err           (oob_err),
    .frame_count       (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One accepted-beat attempt; the outputs of that beat are visible on return.
  task automatic send(input int h, input int v, input logic [23:0] d);
    @(negedge aclk);
    hcount_in         = 11'(h);
    vcount_in         = 10'(v);
    pixel_axis_tdata  = d;
    pixel_axis_tvalid = 1'b1;
    tick();
    pixel_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge aclk);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    aresetn           = 1'b0;
    pixel_axis_tdata  = '0;
    pixel_axis_tvalid = 1'b0;
    hcount_in         = '0;
    vcount_in         = '0;
    swap_req          = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_tready", 32'(pixel_axis_tready), 32'd0);
    check("rst_we",     32'(ram_we),            32'd0);
    check("rst_addr",   32'(ram_addr),          32'd0);
    check("rst_din",    32'(ram_din),           32'd0);
    check("rst_rdbank", 32'(rd_bank),           32'd1);
    check("rst_done",   32'(frame_done),        32'd0);
    check("rst_oob",    32'(oob_err),           32'd0);
    check("rst_fcnt",   32'(frame_count),       32'd0);

    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    check("tready_after_rst", 32'(pixel_axis_tready), 32'd1);

    // First pixel below REGION_DIVIDE: 0 + 140*244 = 34160
    send(390, 530, 24'hF0A050);
    check("t1_we",   32'(ram_we),   32'd1);
    check("t1_addr", 32'(ram_addr), 32'd34160);
    check("t1_din",  32'(ram_din),  32'hFA5);
    check("t1_oob",  32'(oob_err),  32'd0);

    // Idle cycle: no write
    tick();
    check("idle_we", 32'(ram_we), 32'd0);

    // Cylinder region: 392-2 = 390 -> address 0
    send(392, 390, 24'h123456);
    check("cyl_we",   32'(ram_we),   32'd1);
    check("cyl_addr", 32'(ram_addr), 32'd0);
    check("cyl_din",  32'(ram_din),  32'h135);
    check("cyl_oob",  32'(oob_err),  32'd0);

    // 391-2 = 389 is left of the window
    send(391, 390, 24'hFFFFFF);
    check("oob_left_we",  32'(ram_we),            32'd0);
    check("oob_left_err", 32'(oob_err),           32'd1);
    check("oob_tready",   32'(pixel_axis_tready), 32'd1);

    // hcount below the shift must not wrap into the window
    send(1, 400, 24'h0);
    check("oob_wrap_we", 32'(ram_we), 32'd0);
    // Right edge (exclusive) below REGION_DIVIDE, and bottom edge (exclusive)
    send(634, 600, 24'h0);
    check("oob_right_we", 32'(ram_we), 32'd0);
    send(390, 765, 24'h0);
    check("oob_bottom_we", 32'(ram_we), 32'd0);

    // 635-2 = 633 is the last column: 243 + 10*244 = 2683; oob stays sticky
    send(635, 400, 24'h80FF08);
    check("cyl_edge_we",   32'(ram_we),   32'd1);
    check("cyl_edge_addr", 32'(ram_addr), 32'd2683);
    check("cyl_edge_din",  32'(ram_din),  32'h8F0);
    check("oob_sticky",    32'(oob_err),  32'd1);

    // Last row streamed back-to-back; swap_req coincides with the last accept
    for (int h = 390; h < 634; h++) begin
      @(negedge aclk);
      hcount_in         = 11'(h);
      vcount_in         = 10'd764;
      pixel_axis_tdata  = 24'(h * 3);
      pixel_axis_tvalid = 1'b1;
      swap_req          = (h == 633);
      tick();
      check("row_we",     32'(ram_we),            32'd1);
      check("row_addr",   32'(ram_addr),          32'(h - 390 + 91256));
      check("row_done",   32'(frame_done),        32'(h == 633));
      check("row_tready", 32'(pixel_axis_tready), 32'(h != 633));
    end
    pixel_axis_tvalid = 1'b0;
    swap_req          = 1'b0;
    check("last_rdbank", 32'(rd_bank),     32'd1);
    check("last_fcnt",   32'(frame_count), 32'd0);

    // Swap on the last accept was ignored: still waiting, beats refused
    @(negedge aclk);
    pixel_axis_tvalid = 1'b1;
    hcount_in         = 11'd400;
    vcount_in         = 10'd600;
    tick();
    pixel_axis_tvalid = 1'b0;
    check("wait_done_pulse", 32'(frame_done),        32'd0);
    check("wait_tready",     32'(pixel_axis_tready), 32'd0);
    check("wait_we",         32'(ram_we),            32'd0);
    repeat (3) tick();
    check("wait_rdbank", 32'(rd_bank),           32'd1);
    check("wait_tready2", 32'(pixel_axis_tready), 32'd0);

    // Later swap is honoured
    pulse_swap();
    check("swap_rdbank", 32'(rd_bank),           32'd0);
    check("swap_fcnt",   32'(frame_count),       32'd1);
    check("swap_tready", 32'(pixel_axis_tready), 32'd1);

    send(390, 530, 24'h0F0F0F);
    check("bank1_we",   32'(ram_we),   32'd1);
    check("bank1_addr", 32'(ram_addr), 32'(BANK1 + 34160));
    check("bank1_din",  32'(ram_din),  32'h000);

    // Reset mid-frame with a beat being presented
    @(negedge aclk);
    hcount_in         = 11'd500;
    vcount_in         = 10'd600;
    pixel_axis_tvalid = 1'b1;
    aresetn           = 1'b0;
    tick();
    check("mrst_we",     32'(ram_we),            32'd0);
    check("mrst_tready", 32'(pixel_axis_tready), 32'd0);
    check("mrst_rdbank", 32'(rd_bank),           32'd1);
    check("mrst_fcnt",   32'(frame_count),       32'd0);
    check("mrst_oob",    32'(oob_err),           32'd0);
    pixel_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    check("mrst_tready_up", 32'(pixel_axis_tready), 32'd1);

    // Frames with only the last pixel still complete; frame_count wraps 255->0
    for (int i = 0; i < 256; i++) begin
      send(633, 764, 24'h0);
      check("wrap_done", 32'(frame_done), 32'd1);
      check("wrap_addr", 32'(ram_addr),   32'((i % 2) * BANK1 + LAST_ADDR));
      pulse_swap();
      check("wrap_fcnt",   32'(frame_count),       32'((i + 1) % 256));
      check("wrap_rdbank", 32'(rd_bank),           32'(1 - ((i + 1) % 2)));
      check("wrap_tready", 32'(pixel_axis_tready), 32'd1);
    end
    check("wrap_zero", 32'(frame_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
